alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Registered execute stage for the single-cycle MIPS datapath.
- Combines ALU-control decode (aluop + funct → 3-bit ALU select), a 32-bit ALU with zero/carry/negative/overflow flags, and two address adders (PC+4 and branch target).
- All results are captured in one output register stage, giving 1-cycle latency.

Parameters:
- none (datapath fixed at 32 bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid this cycle
- aluop1  in  1  ALU op class, high bit
- aluop0  in  1  ALU op class, low bit
- funct  in  4  instruction bits [3:0]
- a  in  32  operand A (rs data)
- b  in  32  operand B (rt data or sign-extended immediate)
- pc  in  32  current program counter
- imm16  in  16  instruction bits [15:0]
- out_valid  out  1  registered in_valid
- alu_ctl  out  3  registered ALU select (gout)
- result  out  32  registered ALU result
- zero  out  1  result == 0
- carry  out  1  adder carry-out
- neg  out  1  result[31]
- ovf  out  1  signed overflow
- pc_plus4  out  32  pc + 4
- branch_target  out  32  pc + 4 + (sext(imm16) << 2)

Behaviour:
- Reset: while rst_n = 0, every output is 0, asynchronously; release takes effect on the next clk edge.
- Each rising clk edge registers all outputs from the current inputs, whatever in_valid is. out_valid <= in_valid. Latency is exactly 1 cycle, with no stalls and no backpressure.
- ALU control decode (combinational, then registered as alu_ctl):
  - aluop1=0, aluop0=0 → 010 ADD (lw/sw)
  - aluop1=0, aluop0=1 → 110 SUB (beq)
  - aluop1=1 (aluop0 ignored) → decode funct:
    - 0000 → 010 ADD
    - 0010 → 110 SUB
    - 0100 → 000 AND
    - 0101 → 001 OR
    - 0110 → 011 XOR
    - 0111 → 100 NOR
    - 1010 → 111 SLT
    - any other funct → 010 ADD
  - Codes 101 are unused and treated as ADD by the ALU.
- ALU operations:
  - ADD: 33-bit a+b; result = bits[31:0], carry = bit 32.
  - SUB: a + ~b + 1; carry = carry-out (1 means no borrow).
  - AND, OR, XOR, NOR: bitwise; carry = 0, ovf = 0.
  - SLT: signed compare. Compute d = a−b; result = 32'h1 if (d[31] XOR signed-overflow) else 0. carry and ovf are reported from the subtraction.
- ovf:
  - ADD: a[31]==b[31] and result[31]!=a[31].
  - SUB/SLT: a[31]!=b[31] and d[31]!=a[31].
  - Otherwise 0.
- zero = (result == 0); neg = result[31]. Both are computed from the final result, so for SLT they reflect the 0/1 value.
- pc_plus4 = pc + 32'h4, modulo 2^32 (wraps).
- branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32.
- All arithmetic is unsigned modulo 2^32 except the SLT decision and ovf.
- Reset asserted mid-stream clears the output registers immediately. The first valid output after release comes 1 edge after in_valid is sampled high.

Test Plan:
- Reset: rst_n=0 asynchronously with stale outputs → all outputs 0 immediately. Release, in_valid=1, aluop=00, a=5, b=7 → next edge: result=12, zero=0, alu_ctl=010, out_valid=1.
- Subtract/branch: aluop=01, a=b=0x1234 → result=0, zero=1, carry=1, alu_ctl=110. Same op with a=0x7FFFFFFF, b=0xFFFFFFFF → result=0x80000000, ovf=1, neg=1.
- Funct decode, a=0xF0F0F0F0, b=0x0FF00FF0, aluop1=1:
  - funct 0100 → 0x00F000F0
  - funct 0101 → 0xFFF0FFF0
  - funct 0110 → 0xFF00FF00
  - funct 0111 → 0x000F000F
  - funct 1111 → alu_ctl=010, result = a+b = 0x00E100E0, carry=1
- SLT: a=0xFFFFFFFF(−1), b=1 → result=1. a=1, b=0xFFFFFFFF → result=0, zero=1. a=0x80000000, b=1 (overflowing subtract) → result=1, ovf=1.
- Adders: pc=0x00000010, imm16=0xFFFE → pc_plus4=0x14, branch_target=0x0C. pc=0xFFFFFFFC, imm16=0x0001 → pc_plus4=0, branch_target=4.
- Back-to-back: in_valid high for 3 consecutive cycles with different ops → each result appears exactly 1 edge later, in order. Dropping in_valid → out_valid drops on the next edge.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Registered execute stage: ALU-control decode, 32-bit ALU with flags,
// and the PC+4 / branch-target adders, all captured in one output register.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  output logic        out_valid,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        neg,
  output logic        ovf,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_XOR = 3'b011;
  localparam logic [2:0] CTL_NOR = 3'b100;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  function automatic logic [2:0] alu_decode(input logic op1, input logic op0,
                                            input logic [3:0] fn);
    logic [2:0] ctl;
    ctl = CTL_ADD;
    if (op1) begin
      case (fn)
        4'b0000: ctl = CTL_ADD;
        4'b0010: ctl = CTL_SUB;
        4'b0100: ctl = CTL_AND;
        4'b0101: ctl = CTL_OR;
        4'b0110: ctl = CTL_XOR;
        4'b0111: ctl = CTL_NOR;
        4'b1010: ctl = CTL_SLT;
        default: ctl = CTL_ADD;
      endcase
    end else if (op0) begin
      ctl = CTL_SUB;
    end else begin
      ctl = CTL_ADD;
    end
    return ctl;
  endfunction

  logic [2:0]  w_ctl;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic        w_slt;
  logic [31:0] w_result;
  logic        w_carry;
  logic        w_ovf;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;

  assign w_ctl     = alu_decode(aluop1, aluop0, funct);
  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign w_add_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
  assign w_sub_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);
  // Signed less-than: sign of the difference corrected by overflow.
  assign w_slt     = w_diff[31] ^ w_sub_ovf;

  assign w_pc_plus4      = pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  // ALU operation select; unused code 101 falls through to ADD.
  always_comb begin
    w_result = w_sum[31:0];
    w_carry  = w_sum[32];
    w_ovf    = w_add_ovf;
    case (w_ctl)
      CTL_AND: begin w_result = a & b;    w_carry = 1'b0; w_ovf = 1'b0; end
      CTL_OR:  begin w_result = a | b;    w_carry = 1'b0; w_ovf = 1'b0; end
      CTL_XOR: begin w_result = a ^ b;    w_carry = 1'b0; w_ovf = 1'b0; end
      CTL_NOR: begin w_result = ~(a | b); w_carry = 1'b0; w_ovf = 1'b0; end
      CTL_SUB: begin
        w_result = w_diff[31:0];
        w_carry  = w_diff[32];
        w_ovf    = w_sub_ovf;
      end
      CTL_SLT: begin
        w_result = {31'd0, w_slt};
        w_carry  = w_diff[32];
        w_ovf    = w_sub_ovf;
      end
      default: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
        w_ovf    = w_add_ovf;
      end
    endcase
  end

  logic        r_valid;
  logic [2:0]  r_ctl;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_carry;
  logic        r_neg;
  logic        r_ovf;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_branch_target;

  // Output stage: captures every cycle regardless of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_ctl           <= 3'd0;
      r_result        <= 32'd0;
      r_zero          <= 1'b0;
      r_carry         <= 1'b0;
      r_neg           <= 1'b0;
      r_ovf           <= 1'b0;
      r_pc_plus4      <= 32'd0;
      r_branch_target <= 32'd0;
    end else begin
      r_valid         <= in_valid;
      r_ctl           <= w_ctl;
      r_result        <= w_result;
      r_zero          <= (w_result == 32'd0);
      r_carry         <= w_carry;
      r_neg           <= w_result[31];
      r_ovf           <= w_ovf;
      r_pc_plus4      <= w_pc_plus4;
      r_branch_target <= w_branch_target;
    end
  end

  assign out_valid     = r_valid;
  assign alu_ctl       = r_ctl;
  assign result        = r_result;
  assign zero          = r_zero;
  assign carry         = r_carry;
  assign neg           = r_neg;
  assign ovf           = r_ovf;
  assign pc_plus4      = r_pc_plus4;
  assign branch_target = r_branch_target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a behavioural model pushes expected
// results at drive time; a negedge monitor pops them when out_valid is seen.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        aluop1;
  logic        aluop0;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic        out_valid;
  logic [2:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        neg;
  logic        ovf;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
    .a(a), .b(b), .pc(pc), .imm16(imm16),
    .out_valid(out_valid), .alu_ctl(alu_ctl), .result(result),
    .zero(zero), .carry(carry), .neg(neg), .ovf(ovf),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
    logic [31:0] p4;
    logic [31:0] bt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic op1, input logic op0, input logic [3:0] fn,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] p, input logic [15:0] im);
    exp_t   e;
    longint sx;
    longint sy;
    longint sr;
    logic [32:0] wide;
    logic [31:0] off;
    sx = $signed(x);
    sy = $signed(y);
    if (!op1) e.ctl = op0 ? 3'b110 : 3'b010;
    else begin
      case (fn)
        4'b0010: e.ctl = 3'b110;
        4'b0100: e.ctl = 3'b000;
        4'b0101: e.ctl = 3'b001;
        4'b0110: e.ctl = 3'b011;
        4'b0111: e.ctl = 3'b100;
        4'b1010: e.ctl = 3'b111;
        default: e.ctl = 3'b010;
      endcase
    end
    e.c = 1'b0;
    e.v = 1'b0;
    case (e.ctl)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b011: e.res = x ^ y;
      3'b100: e.res = ~(x | y);
      3'b110, 3'b111: begin
        sr    = sx - sy;
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.c   = (x >= y);
        e.res = (e.ctl == 3'b110) ? (x - y) : (($signed(x) < $signed(y)) ? 32'd1 : 32'd0);
      end
      default: begin
        wide  = {1'b0, x} + {1'b0, y};
        e.res = wide[31:0];
        e.c   = wide[32];
        sr    = sx + sy;
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
    endcase
    e.z  = (e.res == 32'd0);
    e.n  = e.res[31];
    e.p4 = p + 32'd4;
    off  = {{16{im[15]}}, im} << 2;
    e.bt = e.p4 + off;
    return e;
  endfunction

  // Bench-side valid pipe used to judge out_valid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_valid <= 1'b0;
    else        exp_valid <= in_valid;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("alu_ctl", 32'(alu_ctl), 32'(e.ctl));
          check("result", result, e.res);
          check("zero", 32'(zero), 32'(e.z));
          check("carry", 32'(carry), 32'(e.c));
          check("neg", 32'(neg), 32'(e.n));
          check("ovf", 32'(ovf), 32'(e.v));
          check("pc_plus4", pc_plus4, e.p4);
          check("branch_target", branch_target, e.bt);
        end
      end
    end
  end

  task automatic send(input logic op1, input logic op0, input logic [3:0] fn,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, input logic [15:0] im);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    aluop1 = op1; aluop0 = op0; funct = fn;
    a = x; b = y; pc = p; imm16 = im;
    q.push_back(model(op1, op0, fn, x, y, p, im));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; funct = 4'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_alu_ctl"}, 32'(alu_ctl), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, {28'd0, zero, carry, neg, ovf}, 32'd0);
    check({tag, "_pc_plus4"}, pc_plus4, 32'd0);
    check({tag, "_branch_target"}, branch_target, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; aluop1 = 1'b0; aluop0 = 1'b0; funct = 4'd0;
    a = 32'd0; b = 32'd0; pc = 32'd0; imm16 = 16'd0;
    #22;
    check_all_zero("reset");
    rst_n = 1'b1;

    send(1'b0, 1'b0, 4'd0, 32'd5, 32'd7, 32'h0000_1000, 16'h0004);
    idle(2);

    // Stale outputs, then an asynchronous reset between edges.
    send(1'b1, 1'b0, 4'b0101, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0040_0000, 16'h8000);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    send(1'b0, 1'b1, 4'd0, 32'h0000_1234, 32'h0000_1234, 32'd0, 16'd0);
    send(1'b0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 16'd0);
    send(1'b1, 1'b1, 4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b0010, 32'd3, 32'd5, 32'd0, 16'd0);
    idle(1);
    send(1'b1, 1'b0, 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b1010, 32'd1, 32'hFFFF_FFFF, 32'd0, 16'd0);
    send(1'b1, 1'b0, 4'b1010, 32'h8000_0000, 32'd1, 32'd0, 16'd0);
    send(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0000_0010, 16'hFFFE);
    send(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0001);
    idle(2);

    for (int i = 0; i < 24; i++) begin
      send(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 16'($urandom));
      if (i % 5 == 4) idle(1);
    end
    idle(3);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
